spi_reg_initiator: RTL
======================

# spi_reg_initiator

SPI mode-0 peripheral front-end that turns serial frames from an external SPI controller into single-access transactions on the register-bank application interface (wr_rdn/addr/wdata/we/rdata/ack/err). It sits between the chip pins and the register bank. It is the initiator side of that interface and serves both config writes and config/status reads. All SPI inputs are oversampled in the clk domain; no logic runs on spi_sclk.

## Interface
Parameters:
- REG_W, 8, data width; must match the register bank.
- ADDR_W, 8, address width; addr MSB = 1 selects status registers.

Ports (reset rstb asynchronous, active-low; clock clk):
- clk  in  1  system clock
- rstb  in  1  async active-low reset
- ena  in  1  block enable; low holds FSM in IDLE and drops any frame in progress (a write already issued still completes)
- spi_cs_n  in  1  chip select, active low, asynchronous to clk
- spi_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
- spi_mosi  in  1  serial data in, MSB first
- spi_miso  out  1  serial data out, MSB first
- spi_miso_oe  out  1  MISO output enable; 1 while spi_cs_n is low (synchronised)
- wr_rdn  out  1  1 = write access, 0 = read access
- addr  out  ADDR_W  access address
- wdata  out  REG_W  write data
- we  out  1  access request, held until ack
- rdata  in  REG_W  read data, valid in ack cycle
- ack  in  1  access complete
- err  in  1  access error, sampled with ack
- busy  out  1  FSM not IDLE
- frame_err  out  1  one-cycle pulse: frame aborted by spi_cs_n rise
- bus_err  out  1  one-cycle pulse: err=1 with ack, or read data late

## Operation
- Frame: 1 cmd bit (1=write, 0=read), then ADDR_W address bits, then REG_W data bits, MSB first. Default length 17 bits.
- Sync: spi_cs_n, spi_sclk and spi_mosi each pass through a 2-FF synchroniser. Edges are detected from the 3rd FF stage. MOSI is sampled on detected sclk rise.
- FSM states:
  - IDLE: waits for synced cs_n fall; clears the bit counter.
  - CMD: shifts cmd+addr. After bit 1+ADDR_W: a read goes to RD_REQ, a write goes to WDATA.
  - RD_REQ: drives wr_rdn=0, we=1 and addr, held until ack. On ack, rdata loads the TX shift register, then DATA.
  - DATA: read data phase. The MSB is driven immediately on load. The first detected sclk fall in DATA is skipped; each later fall shifts out the next bit. After REG_W bits, DONE.
  - WDATA: shifts REG_W bits. On the last bit, WR_REQ.
  - WR_REQ: drives wr_rdn=1, we=1, addr and wdata, held until ack, then DONE.
  - DONE: extra sclk edges are ignored and spi_miso=0. Returns to IDLE on cs_n rise.
- we is an access strobe for both reads and writes (the register bank writes only when we=1 with wr_rdn=1; integration gates the bank's we with wr_rdn).
- cs_n rise in CMD, WDATA or DATA: no access is issued, frame_err pulses, go to IDLE.
- cs_n rise during RD_REQ or WR_REQ: the access completes (atomic), then IDLE. frame_err pulses only for RD_REQ, because the read data is lost.
- ack with err=1: bus_err pulses and the access is still considered done. For reads, the TX register loads 0.
- A second access is never issued within one frame.

## Timing
- Reset values: spi_miso=0, spi_miso_oe=0, wr_rdn=0, addr=0, wdata=0, we=0, busy=0, frame_err=0, bus_err=0; FSM=IDLE.
- Pin-to-detect latency: 3 clk cycles for any input edge.
- Requirement on the SPI controller: sclk high and low times ≥ 6 clk periods each; cs_n setup to the first sclk rise ≥ 4 clk periods.
- Read: we rises 1 cycle after the last address bit's detected rise. With ack tied high, rdata is captured in that cycle and spi_miso = MSB on the next cycle.
- Ack latency: any ack latency is legal for writes. For reads, ack must arrive before the first detected sclk rise of the data phase. Otherwise bus_err pulses, that frame's MISO stays 0 and the late ack is consumed.
- Write: we rises 1 cycle after the final bit's detected rise; we falls the cycle after ack is seen high.
- Reset asserted mid-frame: all outputs return to reset values immediately; no partial write.

## Test plan
- Write frame cmd=1, addr=0x03, data=0x5A with ack tied 1 -> exactly one we pulse with wr_rdn=1, addr=0x03, wdata=0x5A; busy returns to 0 after cs_n rise.
- Read frame cmd=0, addr=0x82, rdata model returns 0xC3 -> we pulse with wr_rdn=0, addr=0x82; MISO bits 1,1,0,0,0,0,1,1 sampled on sclk rises 10-17.
- cs_n rises after 5 bits -> no we, frame_err one pulse, next full write frame succeeds.
- Write with ack delayed 4 cycles and err=1 -> we held 5 cycles, bus_err one pulse, addr and wdata stable throughout.
- 20-clock frame (3 extra clocks after a read) -> single access, MISO=0 on extra bits, no frame_err.
- rstb asserted during WDATA bit 12 -> all outputs zero the same cycle, no we; after release, a fresh frame completes correctly.

Source files
------------

// File: rtl/spi_reg_initiator_if.sv
// Register-bank access bus between the SPI front-end (master) and the register bank (slave).
interface spi_reg_initiator_if #(
  parameter int unsigned REG_W  = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              wr_rdn;
  logic [ADDR_W-1:0] addr;
  logic [REG_W-1:0]  wdata;
  logic              we;
  logic [REG_W-1:0]  rdata;
  logic              ack;
  logic              err;

  modport master (output wr_rdn, addr, wdata, we, input rdata, ack, err);
  modport slave  (input wr_rdn, addr, wdata, we, output rdata, ack, err);
endinterface

// File: rtl/spi_reg_initiator.sv
// SPI mode-0 peripheral that converts cmd/addr/data frames into single register-bank accesses.
// All SPI pins are oversampled in the clk domain.
module spi_reg_initiator #(
  parameter int unsigned REG_W  = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                ena,
  input  logic                spi_cs_n,
  input  logic                spi_sclk,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic                spi_miso_oe,
  spi_reg_initiator_if.master bus,
  output logic                busy,
  output logic                frame_err,
  output logic                bus_err
);

  localparam int unsigned CA_W     = ADDR_W + 1;
  localparam int unsigned MAX_BITS = (CA_W > REG_W) ? CA_W : REG_W;
  localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_RD_REQ, S_DATA, S_WDATA, S_WR_REQ, S_DONE
  } state_t;

  // Two-stage synchronisers; cs_n and sclk get a third stage for edge detection.
  logic [2:0] cs_q, sclk_q;
  logic [1:0] mosi_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cs_q   <= 3'b111;
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      cs_q   <= {cs_q[1:0], spi_cs_n};
      sclk_q <= {sclk_q[1:0], spi_sclk};
      mosi_q <= {mosi_q[0], spi_mosi};
    end
  end

  logic cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_s;
  assign cs_fall   = ~cs_q[1] &  cs_q[2];
  assign cs_rise   =  cs_q[1] & ~cs_q[2];
  assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] &  sclk_q[2];
  assign mosi_s    =  mosi_q[1];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ca_q, ca_d;
  logic [REG_W-1:0]  rx_q, rx_d;
  logic [REG_W-1:0]  tx_q, tx_d;
  logic              skip_q, skip_d;
  logic              abort_q, abort_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              wr_rdn_q, wr_rdn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REG_W-1:0]  wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              ferr_q, ferr_d;
  logic              berr_q, berr_d;

  logic [ADDR_W:0]   ca_full;
  logic [REG_W-1:0]  rx_full;
  logic              late_c;
  assign ca_full = {ca_q, mosi_s};
  assign rx_full = {rx_q[REG_W-2:0], mosi_s};
  assign late_c  = sclk_rise & ~abort_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ca_q     <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      skip_q   <= 1'b0;
      abort_q  <= 1'b0;
      miso_q   <= 1'b0;
      oe_q     <= 1'b0;
      wr_rdn_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ca_q     <= ca_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      skip_q   <= skip_d;
      abort_q  <= abort_d;
      miso_q   <= miso_d;
      oe_q     <= oe_d;
      wr_rdn_q <= wr_rdn_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      ferr_q   <= ferr_d;
      berr_q   <= berr_d;
    end
  end

  // Frame sequencing; an issued access is held until ack regardless of cs_n/ena.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ca_d     = ca_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    skip_d   = skip_q;
    abort_d  = abort_q;
    wr_rdn_d = wr_rdn_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q & ~bus.ack;
    ferr_d   = 1'b0;
    berr_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        if (ena && cs_fall && !we_q) state_d = S_CMD;
      end
      S_CMD: begin
        if (!ena) begin
          state_d = S_IDLE;
        end else if (cs_rise) begin
          ferr_d  = 1'b1;
          state_d = S_IDLE;
        end else if (sclk_rise) begin
          ca_d  = ca_full[ADDR_W-1:0];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_W)) begin
            cnt_d = '0;
            if (ca_full[ADDR_W]) begin
              state_d = S_WDATA;
            end else begin
              state_d  = S_RD_REQ;
              we_d     = 1'b1;
              wr_rdn_d = 1'b0;
              addr_d   = ca_full[ADDR_W-1:0];
              skip_d   = 1'b1;
            end
          end
        end
      end
      S_RD_REQ: begin
        if (sclk_fall) skip_d = 1'b0;
        if (cs_rise) begin
          abort_d = 1'b1;
          ferr_d  = 1'b1;
        end else if (!ena) begin
          abort_d = 1'b1;
        end
        // A data-phase sclk rise before ack means the MISO slot is already gone.
        if (late_c) begin
          berr_d  = 1'b1;
          tx_d    = '0;
          cnt_d   = CNT_W'(1);
          state_d = S_DATA;
        end else if (bus.ack) begin
          berr_d  = bus.err;
          tx_d    = bus.err ? '0 : bus.rdata;
          state_d = (abort_q || cs_rise || !ena) ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (!ena) begin
          state_d = S_IDLE;
        end else if (cs_rise) begin
          ferr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (sclk_fall) begin
            if (skip_q) skip_d = 1'b0;
            else        tx_d   = {tx_q[REG_W-2:0], 1'b0};
          end
          if (sclk_rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(REG_W - 1)) state_d = S_DONE;
          end
        end
      end
      S_WDATA: begin
        if (!ena) begin
          state_d = S_IDLE;
        end else if (cs_rise) begin
          ferr_d  = 1'b1;
          state_d = S_IDLE;
        end else if (sclk_rise) begin
          rx_d  = rx_full;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(REG_W - 1)) begin
            state_d  = S_WR_REQ;
            we_d     = 1'b1;
            wr_rdn_d = 1'b1;
            addr_d   = ca_q;
            wdata_d  = rx_full;
          end
        end
      end
      S_WR_REQ: begin
        if (cs_rise || !ena) abort_d = 1'b1;
        if (bus.ack) begin
          berr_d  = bus.err;
          state_d = (abort_q || cs_rise || !ena) ? S_IDLE : S_DONE;
        end
      end
      S_DONE: begin
        if (!ena || cs_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output staging: MISO only carries data in the data phase.
  always_comb begin
    miso_d = (state_d == S_DATA) ? tx_d[REG_W-1] : 1'b0;
    oe_d   = ~cs_q[1];
    busy_d = (state_d != S_IDLE);
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign bus.wr_rdn  = wr_rdn_q;
  assign bus.addr    = addr_q;
  assign bus.wdata   = wdata_q;
  assign bus.we      = we_q;
  assign busy        = busy_q;
  assign frame_err   = ferr_q;
  assign bus_err     = berr_q;

endmodule
